sram_like_arb: RTL and testbench
================================

# sram_like_arb

Parametrised bridge that arbitrates NCH CPU-side sram-like request channels (req/wr/size/addr/wdata → addr_ok/data_ok/rdata) onto one synchronous SRAM port with a configurable read latency. It sits between the core (instruction, data and future uncached/debug channels) and the on-chip SRAM in the non-AXI build. It adds round-robin arbitration, lane-aware byte enables and a latency-matched response pipeline that routes data_ok back to the issuing channel.

## Interface
- NCH, 2, number of request channels (1..8); channel 0 has priority after reset.
- ADDR_W, 32, address width; data width is fixed at 32.
- LAT, 1, SRAM read latency in cycles from address to rdata (1..4).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NCH  per-channel request.
- wr  in  NCH  per-channel write flag.
- size  in  2*NCH  per-channel size (0 = byte, 1 = half, 2 = word).
- addr  in  ADDR_W*NCH  per-channel byte address.
- wdata  in  32*NCH  per-channel write data, already lane-aligned by the requester.
- addr_ok  out  NCH  one-hot grant; the request is accepted this cycle.
- data_ok  out  NCH  one-hot response strobe.
- rdata  out  32  read data, shared; valid while any data_ok bit is set.
- err  out  NCH  response error flag, qualified by data_ok.
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W  word-aligned SRAM address, {addr[ADDR_W-1:2], 2'b00}.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.

## Operation
- **Arbitration**
  - Priority pointer ptr, log2(NCH) bits, reset value 0.
  - Each cycle the grant goes to the first channel with req set, searching ptr, ptr+1, … modulo NCH.
  - At most one grant per cycle.
  - On a grant to channel i, ptr becomes (i+1) mod NCH at the clock edge. With no grant, ptr holds.
  - addr_ok[i] is combinational: it equals the grant and is forced to 0 while rst is high.
- **Issue**
  - The granted request drives the SRAM port in the same cycle.
  - sram_en = 1 only when a grant exists and is issuable.
  - sram_wdata is the granted channel's wdata, passed unshifted.
- **Byte enables**
  - sram_wen is 0 for reads and whenever there is no grant.
  - For writes:
    - size 0 → 4'b0001 << addr[1:0]
    - size 1 → 4'b0011 << addr[1:0], truncated to 4 bits
    - size 2 or 3 → 4'b1111
- **Response pipeline**
  - A LAT-stage shift register; each stage holds {valid, channel id, err}.
  - Every granted request enters stage 1, including writes, so responses stay in issue order.
  - When stage LAT is valid:
    - data_ok[id] = 1 for one cycle;
    - rdata = sram_rdata for reads, 0 for writes;
    - err[id] = stored err.
- **Flow control**
  - There is no backpressure on responses: requesters must accept data_ok in the cycle it is asserted.
  - Back-to-back grants, one per cycle, are fully pipelined.
- **Reset**
  - ptr = 0 and all stage valid bits = 0.
  - data_ok = 0, err = 0, sram_en = 0, sram_wen = 0.
  - Requests in flight when reset asserts are dropped and produce no data_ok.

## Timing
- Grant in cycle t → data_ok in cycle t+LAT, for reads and writes alike.
- Throughput is one request per cycle across all channels.
- With ptr = 0, simultaneous req on channels 0 and 1: channel 0 in cycle t, channel 1 in cycle t+1 if it still holds req.
- A channel may re-request in its own data_ok cycle.
- ptr wraps from NCH-1 to 0.
- NCH = 1 degenerates to addr_ok = req with the pipeline intact.

## Configuration
- **SRAM_LIKE_ARB_ALIGN_CHECK_EN defined:**
  - Misaligned requests are granted (addr_ok = 1) but not issued: sram_en = 0, sram_wen = 0.
  - Misaligned means: size 1 with addr[0] = 1, size 2 with addr[1:0] ≠ 0, or size 3 at any address.
  - The response still arrives at t+LAT with err = 1 and rdata = 0.
- **Not defined:**
  - err is tied to 0 and no check is made.
  - Byte enables follow the shift rules above.

## Structure
- Shared package sram_like_pkg holds:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - a wen-generation function (size, addr[1:0], wr) → 4-bit mask;
  - the response-stage struct {valid, id, err}.
- One sub-module, rr_arbiter (NCH req in, one-hot grant out, pointer update on an accept input), reusable by the future AXI-side bridge.

## Test plan
- NCH = 2, LAT = 1: ch0 read of 0x100 with SRAM returning 0xDEADBEEF → addr_ok[0] in cycle t, data_ok[0] in t+1, rdata = 0xDEADBEEF.
- ch0 byte write at 0x103, wdata 0xAB000000 → sram_wen = 4'b1000, sram_addr = 0x100; half write at 0x102 → 4'b1100.
- Both channels request continuously for 6 cycles → grants alternate 0,1,0,1,0,1 and each data_ok matches its grant delayed by LAT.
- LAT = 3, back-to-back reads 0x0, 0x4, 0x8 on ch1 → three consecutive data_ok[1] pulses in t+3..t+5, in issue order.
- rst asserted one cycle after a read grant with LAT = 2 → no data_ok; after release ptr = 0 and all outputs are 0.
- With SRAM_LIKE_ARB_ALIGN_CHECK_EN: word read at 0x102 → sram_en = 0, data_ok with err = 1 and rdata = 0. Without the macro: issued with sram_addr = 0x100, err = 0.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like request bridge: size encoding,
// byte-enable generation and the response pipeline stage record.
package sram_like_pkg;

    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
        logic            rd;
    } resp_stage_t;

    function automatic logic [3:0] gen_wen(input logic [1:0] size,
                                           input logic [1:0] lane,
                                           input logic       wr);
        logic [3:0] mask;
        mask = '0;
        if (wr) begin
            case (size)
                SZ_BYTE: mask = 4'b0001 << lane;
                SZ_HALF: mask = 4'b0011 << lane;
                default: mask = 4'b1111;
            endcase
        end
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_like_arb_if.sv
// CPU-side sram-like request/response bundle for NCH channels.
interface sram_like_arb_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32
);
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        wr;
    logic [2*NCH-1:0]      size;
    logic [ADDR_W*NCH-1:0] addr;
    logic [32*NCH-1:0]     wdata;
    logic [NCH-1:0]        addr_ok;
    logic [NCH-1:0]        data_ok;
    logic [31:0]           rdata;
    logic [NCH-1:0]        err;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/sram_like_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr upward, ptr moves
// past the winner when the grant is accepted.
module rr_arbiter
    import sram_like_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            accept,
    output logic [NCH-1:0]  grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_any
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(ptr) + k) % NCH;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && grant_any) begin
            ptr <= PW'((32'(grant_id) + 32'd1) % NCH);
        end
    end

endmodule

// File: rtl/sram_like_arb.sv
// NCH-channel sram-like to single SRAM port bridge with round-robin grant and a
// LAT-deep response pipeline. Optional alignment checking: SRAM_LIKE_ARB_ALIGN_CHECK_EN.
module sram_like_arb
    import sram_like_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_like_arb_if.slave    cpu,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    logic [NCH-1:0]    grant;
    logic [ID_W-1:0]   gid;
    logic              gany;
    logic              valid_g;
    logic              mis;
    logic              issue;

    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    logic [NCH-1:0]    data_ok_c;
    logic [NCH-1:0]    err_c;
    logic [31:0]       rdata_c;

    resp_stage_t       pipe [LAT];

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (cpu.req),
        .accept    (~rst),
        .grant     (grant),
        .grant_id  (gid),
        .grant_any (gany)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_wr    = cpu.wr[i];
                sel_size  = cpu.size[2*i +: 2];
                sel_addr  = cpu.addr[ADDR_W*i +: ADDR_W];
                sel_wdata = cpu.wdata[32*i +: 32];
            end
        end
    end

    assign valid_g = gany & ~rst;

`ifdef SRAM_LIKE_ARB_ALIGN_CHECK_EN
    assign mis = valid_g & is_misaligned(sel_size, sel_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign issue       = valid_g & ~mis;
    assign cpu.addr_ok = rst ? '0 : grant;
    assign sram_en     = issue;
    assign sram_wen    = issue ? gen_wen(sel_size, sel_addr[1:0], sel_wr) : 4'b0000;
    assign sram_addr   = {sel_addr[ADDR_W-1:2], 2'b00};
    assign sram_wdata  = sel_wdata;

    // Writes and rejected requests also occupy a slot so responses stay in issue order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= valid_g;
            pipe[0].id    <= gid;
            pipe[0].err   <= mis;
            pipe[0].rd    <= issue & ~sel_wr;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_comb begin
        data_ok_c = '0;
        err_c     = '0;
        rdata_c   = '0;
        if (!rst && pipe[LAT-1].valid) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (pipe[LAT-1].id == ID_W'(i)) begin
                    data_ok_c[i] = 1'b1;
                    err_c[i]     = pipe[LAT-1].err;
                end
            end
            if (pipe[LAT-1].rd) begin
                rdata_c = sram_rdata;
            end
        end
    end

    assign cpu.data_ok = data_ok_c;
    assign cpu.err     = err_c;
    assign cpu.rdata   = rdata_c;

endmodule

// File: tb/tb_sram_like_arb.sv
// Scoreboard bench for sram_like_arb: byte-level memory reference model, expected
// responses queued at grant time and checked by an independent monitor.
module tb_sram_like_arb;

    localparam int NCH    = 3;
    localparam int ADDR_W = 32;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    always #5 clk = ~clk;

    sram_like_arb_if #(.NCH(NCH), .ADDR_W(ADDR_W)) bus ();

    sram_like_arb #(.NCH(NCH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (bus),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural SRAM with LAT-cycle read latency.
    logic [31:0] mem     [256];
    logic [31:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
        end else begin
            if (sram_en) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            rd_pipe[0] <= (sram_en && sram_wen == 4'b0000) ? mem[sram_addr[9:2]] : 32'h0;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign sram_rdata = rd_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        e;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          exp_ptr;
    logic [7:0]  ref_mem [1024];

    logic [NCH-1:0] s_req, s_wr;
    logic [1:0]     s_size  [NCH];
    logic [9:0]     s_addr  [NCH];
    logic [31:0]    s_wdata [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every data_ok pulse must match the oldest outstanding grant.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_data_ok @cyc %0d: got none expected ch %0d due %0d",
                         cyc, q[0].ch, q[0].due);
                void'(q.pop_front());
            end
            if (bus.data_ok != '0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_data_ok @cyc %0d: got %b expected none", cyc, bus.data_ok);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("data_ok_chan", 32'(bus.data_ok), 32'(1) << e.ch);
                    check("data_ok_time", cyc, e.due);
                    check("rdata", bus.rdata, e.data);
                    check("err", 32'(bus.err), e.e ? (32'(1) << e.ch) : 32'h0);
                end
            end
        end
    end

    task automatic clear_all();
        s_req = '0;
        s_wr  = '0;
        for (int i = 0; i < NCH; i++) begin
            s_size[i]  = 2'd0;
            s_addr[i]  = '0;
            s_wdata[i] = '0;
        end
    endtask

    task automatic set_ch(input int i, input logic w, input logic [1:0] sz,
                          input logic [9:0] a, input logic [31:0] d);
        s_req[i]   = 1'b1;
        s_wr[i]    = w;
        s_size[i]  = sz;
        s_addr[i]  = a;
        s_wdata[i] = d;
    endtask

    task automatic step(input logic do_rst);
        int          g;
        int          base, lo, hi;
        logic        mis;
        logic [3:0]  mask;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        rst = do_rst;
        bus.req = s_req;
        bus.wr  = s_wr;
        for (int i = 0; i < NCH; i++) begin
            bus.size[2*i +: 2]           = s_size[i];
            bus.addr[ADDR_W*i +: ADDR_W] = ADDR_W'(s_addr[i]);
            bus.wdata[32*i +: 32]        = s_wdata[i];
        end
        #1;
        if (do_rst) begin
            check("addr_ok_in_rst", 32'(bus.addr_ok), 32'h0);
            check("sram_en_in_rst", 32'(sram_en), 32'h0);
            check("sram_wen_in_rst", 32'(sram_wen), 32'h0);
            q.delete();
            exp_ptr = 0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        end else begin
            g = -1;
            for (int k = 0; k < NCH; k++)
                if (g < 0 && s_req[(exp_ptr + k) % NCH]) g = (exp_ptr + k) % NCH;
            check("addr_ok", 32'(bus.addr_ok), (g < 0) ? 32'h0 : (32'(1) << g));
            if (g < 0) begin
                check("sram_en_idle", 32'(sram_en), 32'h0);
                check("sram_wen_idle", 32'(sram_wen), 32'h0);
            end else begin
                base = int'(s_addr[g]) & ~3;
                if (s_size[g] >= 2) begin
                    lo = 0; hi = 3;
                end else begin
                    lo = int'(s_addr[g]) % 4;
                    hi = lo + ((s_size[g] == 2'd1) ? 1 : 0);
                    if (hi > 3) hi = 3;
                end
`ifdef SRAM_LIKE_ARB_ALIGN_CHECK_EN
                mis = (s_size[g] == 2'd1 && s_addr[g][0]) ||
                      (s_size[g] == 2'd2 && s_addr[g][1:0] != 2'b00) ||
                      (s_size[g] == 2'd3);
`else
                mis = 1'b0;
`endif
                mask = 4'b0000;
                if (s_wr[g] && !mis)
                    for (int b = lo; b <= hi; b++) mask[b] = 1'b1;
                check("sram_en", 32'(sram_en), mis ? 32'h0 : 32'h1);
                check("sram_wen", 32'(sram_wen), 32'(mask));
                check("sram_wdata", sram_wdata, s_wdata[g]);
                if (!mis) check("sram_addr", sram_addr, 32'(base));
                rd = 32'h0;
                if (!s_wr[g] && !mis)
                    for (int b = 0; b < 4; b++) rd[8*b +: 8] = ref_mem[base + b];
                for (int b = 0; b < 4; b++)
                    if (mask[b]) ref_mem[base + b] = s_wdata[g][8*b +: 8];
                q.push_back('{ch: g, data: rd, e: mis, due: cyc + LAT});
                exp_ptr = (g + 1) % NCH;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        clear_all();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("rdata_after_rst", bus.rdata, 32'h0);
        check("data_ok_after_rst", 32'(bus.data_ok), 32'h0);
        check("err_after_rst", 32'(bus.err), 32'h0);

        // Word write then read-back at 0x100.
        clear_all(); set_ch(0, 1'b1, 2'd2, 10'h100, 32'hDEADBEEF); step(1'b0);
        clear_all(); set_ch(0, 1'b0, 2'd2, 10'h100, 32'h0); step(1'b0);
        // Sub-word writes with lane masks.
        clear_all(); set_ch(0, 1'b1, 2'd0, 10'h103, 32'hAB000000); step(1'b0);
        clear_all(); set_ch(0, 1'b1, 2'd1, 10'h102, 32'h12340000); step(1'b0);
        clear_all(); set_ch(0, 1'b0, 2'd2, 10'h100, 32'h0); step(1'b0);

        // Two channels competing continuously.
        clear_all();
        set_ch(0, 1'b0, 2'd2, 10'h100, 32'h0);
        set_ch(1, 1'b0, 2'd2, 10'h104, 32'h0);
        repeat (6) step(1'b0);

        // Back-to-back reads on one channel.
        clear_all(); set_ch(1, 1'b0, 2'd2, 10'h000, 32'h0); step(1'b0);
        clear_all(); set_ch(1, 1'b0, 2'd2, 10'h004, 32'h0); step(1'b0);
        clear_all(); set_ch(1, 1'b0, 2'd2, 10'h008, 32'h0); step(1'b0);

        // All channels: pointer wrap.
        clear_all();
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 2'd2, 10'(16 * i), 32'hC0DE0000 + i);
        repeat (7) step(1'b0);

        // Reset one cycle after a read grant: response dropped.
        clear_all(); set_ch(0, 1'b0, 2'd2, 10'h100, 32'h0); step(1'b0);
        clear_all(); step(1'b1);
        step(1'b0);
        check("rdata_post_rst", bus.rdata, 32'h0);
        check("data_ok_post_rst", 32'(bus.data_ok), 32'h0);
        clear_all(); set_ch(1, 1'b0, 2'd2, 10'h000, 32'h0); set_ch(2, 1'b0, 2'd2, 10'h000, 32'h0);
        step(1'b0);

        // Misaligned word read.
        clear_all(); set_ch(2, 1'b0, 2'd2, 10'h102, 32'h0); step(1'b0);
        clear_all(); step(1'b0);

        // Randomised traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NCH; i++) begin
                s_req[i]   = ($urandom_range(0, 3) != 0);
                s_wr[i]    = 1'($urandom_range(0, 1));
                s_size[i]  = 2'($urandom_range(0, 3));
                s_addr[i]  = 10'($urandom_range(0, 1023));
                s_wdata[i] = $urandom;
            end
            step($urandom_range(0, 149) == 0);
        end

        clear_all();
        repeat (LAT + 3) step(1'b0);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
